// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Brief    : Polyphonic note-to-voice allocator. It retriggers a voice that
//             already holds the note, otherwise it takes the lowest free
//             voice, otherwise it steals the oldest voice.
//  Revision : 1.0  initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES    = 4,
    parameter int NOTE_BITS = 7,
    parameter int RANK_BITS = $clog2(VOICES)
) (
    input  logic                        clk_i,
    input  logic                        nrst_i,
    input  logic                        noteOnStrb_i,
    input  logic                        noteOffStrb_i,
    input  logic [NOTE_BITS-1:0]        note_i,
    input  logic                        allOff_i,
    output logic [VOICES*NOTE_BITS-1:0] voiceNote_o,
    output logic [VOICES-1:0]           voiceGate_o,
    output logic [VOICES-1:0]           voiceTrig_o,
    output logic                        stealStrb_o,
    output logic [$clog2(VOICES+1)-1:0] activeCount_o
);

    localparam int                   CNT_BITS     = $clog2(VOICES+1);
    localparam logic [RANK_BITS-1:0] c_oldestRank = RANK_BITS'(VOICES-1);

    logic [NOTE_BITS-1:0] r_voiceNote [VOICES];
    logic [RANK_BITS-1:0] r_rank      [VOICES];
    logic [VOICES-1:0]    r_voiceGate;
    logic [VOICES-1:0]    r_voiceTrig;
    logic                 r_stealStrb;

    logic                 w_hit;
    logic                 w_anyFree;
    logic [RANK_BITS-1:0] w_hitIdx;
    logic [RANK_BITS-1:0] w_freeIdx;
    logic [RANK_BITS-1:0] w_oldIdx;
    logic [RANK_BITS-1:0] w_tgtIdx;
    logic [RANK_BITS-1:0] w_tgtRank;
    logic                 w_assign;
    logic                 w_steal;
    logic                 w_release;
    logic [CNT_BITS-1:0]  w_count;

    // Scanning downwards lets the lowest-index candidate win each search.
    always_comb begin
        w_hit     = 1'b0;
        w_anyFree = 1'b0;
        w_hitIdx  = '0;
        w_freeIdx = '0;
        w_oldIdx  = '0;
        for (int v = VOICES-1; v >= 0; v--) begin
            if (r_voiceGate[v] && (r_voiceNote[v] == note_i)) begin
                w_hit    = 1'b1;
                w_hitIdx = RANK_BITS'(v);
            end
            if (!r_voiceGate[v]) begin
                w_anyFree = 1'b1;
                w_freeIdx = RANK_BITS'(v);
            end
            if (r_rank[v] == c_oldestRank) begin
                w_oldIdx = RANK_BITS'(v);
            end
        end
    end

    always_comb begin
        w_assign  = noteOnStrb_i && !allOff_i;
        w_steal   = w_assign && !w_hit && !w_anyFree;
        w_release = noteOffStrb_i && !noteOnStrb_i && !allOff_i && w_hit;
        if (w_hit) begin
            w_tgtIdx = w_hitIdx;
        end else if (w_anyFree) begin
            w_tgtIdx = w_freeIdx;
        end else begin
            w_tgtIdx = w_oldIdx;
        end
        w_tgtRank = r_rank[w_tgtIdx];
    end

    always_comb begin
        w_count = '0;
        for (int v = 0; v < VOICES; v++) begin
            w_count = w_count + CNT_BITS'(r_voiceGate[v]);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int v = 0; v < VOICES; v++) begin
                r_voiceNote[v] <= '0;
                r_rank[v]      <= RANK_BITS'(v);
            end
            r_voiceGate <= '0;
            r_voiceTrig <= '0;
            r_stealStrb <= 1'b0;
        end else begin
            r_voiceTrig <= '0;
            r_stealStrb <= w_steal;
            if (allOff_i) begin
                r_voiceGate <= '0;
            end else if (w_assign) begin
                r_voiceGate[w_tgtIdx] <= 1'b1;
                r_voiceTrig[w_tgtIdx] <= 1'b1;
                if (!w_hit) begin
                    r_voiceNote[w_tgtIdx] <= note_i;
                end
                // Move the target to the front; only younger voices age by one.
                for (int v = 0; v < VOICES; v++) begin
                    if (RANK_BITS'(v) == w_tgtIdx) begin
                        r_rank[v] <= '0;
                    end else if (r_rank[v] < w_tgtRank) begin
                        r_rank[v] <= r_rank[v] + 1'b1;
                    end
                end
            end else if (w_release) begin
                r_voiceGate[w_hitIdx] <= 1'b0;
            end
        end
    end

    generate
        for (genvar v = 0; v < VOICES; v++) begin : g_noteOut
            assign voiceNote_o[v*NOTE_BITS +: NOTE_BITS] = r_voiceNote[v];
        end
    endgenerate

    assign voiceGate_o   = r_voiceGate;
    assign voiceTrig_o   = r_voiceTrig;
    assign stealStrb_o   = r_stealStrb;
    assign activeCount_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_allocator
//  Brief    : Directed-vector scoreboard bench for voice_allocator (4 voices).
//  Revision : 1.0  initial release
// ============================================================================
module tb_voice_allocator;

    logic        clk;
    logic        nrst;
    logic        noteOn;
    logic        noteOff;
    logic [6:0]  note;
    logic        allOff;
    logic [27:0] w_voiceNote;
    logic [3:0]  w_voiceGate;
    logic [3:0]  w_voiceTrig;
    logic        w_steal;
    logic [2:0]  w_activeCount;

    typedef struct {
        string       name;
        logic [27:0] notes;
        logic [3:0]  gate;
        logic [3:0]  trig;
        logic        steal;
        logic [2:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    int   nVec  = 0;
    int   nFail = 0;

    voice_allocator #(
        .VOICES    (4),
        .NOTE_BITS (7)
    ) dut (
        .clk_i         (clk),
        .nrst_i        (nrst),
        .noteOnStrb_i  (noteOn),
        .noteOffStrb_i (noteOff),
        .note_i        (note),
        .allOff_i      (allOff),
        .voiceNote_o   (w_voiceNote),
        .voiceGate_o   (w_voiceGate),
        .voiceTrig_o   (w_voiceTrig),
        .stealStrb_o   (w_steal),
        .activeCount_o (w_activeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] nv(int n0, int n1, int n2, int n3);
        return {7'(n3), 7'(n2), 7'(n1), 7'(n0)};
    endfunction

    task automatic compare(exp_t e);
        nVec++;
        if (w_voiceNote !== e.notes || w_voiceGate !== e.gate || w_voiceTrig !== e.trig ||
            w_steal !== e.steal || w_activeCount !== e.cnt) begin
            nFail++;
            $display("FAIL %s: got notes=%h gate=%b trig=%b steal=%b cnt=%0d, expected notes=%h gate=%b trig=%b steal=%b cnt=%0d",
                     e.name, w_voiceNote, w_voiceGate, w_voiceTrig, w_steal, w_activeCount,
                     e.notes, e.gate, e.trig, e.steal, e.cnt);
        end
    endtask

    // Monitor: an expectation queued before an edge is checked on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                @(negedge clk);
                compare(e);
            end
        end
    end

    task automatic vec(string name, logic on, logic off, logic ao, int n,
                       logic [27:0] en, logic [3:0] eg, logic [3:0] et, logic es, int ec);
        exp_t e;
        @(posedge clk);
        #1;
        noteOn  = on;
        noteOff = off;
        allOff  = ao;
        note    = 7'(n);
        e.name  = name;
        e.notes = en;
        e.gate  = eg;
        e.trig  = et;
        e.steal = es;
        e.cnt   = 3'(ec);
        expQ.push_back(e);
    endtask

    task automatic checkNow(string name, logic [27:0] en, logic [3:0] eg, logic [3:0] et,
                            logic es, int ec);
        exp_t e;
        e.name  = name;
        e.notes = en;
        e.gate  = eg;
        e.trig  = et;
        e.steal = es;
        e.cnt   = 3'(ec);
        compare(e);
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            nVec++;
            nFail++;
            $display("FAIL drain: %0d expectations still queued, required 0", expQ.size());
            expQ.delete();
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst    = 1'b0;
        noteOn  = 1'b0;
        noteOff = 1'b0;
        allOff  = 1'b0;
        note    = '0;
        #13;
        checkNow("reset", nv(0, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, 0);
        #10;
        nrst = 1'b1;

        // Fill, steal, edge cases
        vec("on60",       1, 0, 0, 60, nv(60, 0, 0, 0),     4'b0001, 4'b0001, 0, 1);
        vec("on64",       1, 0, 0, 64, nv(60, 64, 0, 0),    4'b0011, 4'b0010, 0, 2);
        vec("on67",       1, 0, 0, 67, nv(60, 64, 67, 0),   4'b0111, 4'b0100, 0, 3);
        vec("on71",       1, 0, 0, 71, nv(60, 64, 67, 71),  4'b1111, 4'b1000, 0, 4);
        vec("idleFull",   0, 0, 0, 0,  nv(60, 64, 67, 71),  4'b1111, 4'b0000, 0, 4);
        vec("steal72",    1, 0, 0, 72, nv(72, 64, 67, 71),  4'b1111, 4'b0001, 1, 4);
        vec("steal74",    1, 0, 0, 74, nv(72, 74, 67, 71),  4'b1111, 4'b0010, 1, 4);
        vec("idleSteal",  0, 0, 0, 0,  nv(72, 74, 67, 71),  4'b1111, 4'b0000, 0, 4);
        vec("offUnheld",  0, 1, 0, 99, nv(72, 74, 67, 71),  4'b1111, 4'b0000, 0, 4);
        vec("onOff55",    1, 1, 0, 55, nv(72, 74, 55, 71),  4'b1111, 4'b0100, 1, 4);
        vec("retrig74",   1, 0, 0, 74, nv(72, 74, 55, 71),  4'b1111, 4'b0010, 0, 4);
        vec("off72",      0, 1, 0, 72, nv(72, 74, 55, 71),  4'b1110, 4'b0000, 0, 3);
        vec("on30Free",   1, 0, 0, 30, nv(30, 74, 55, 71),  4'b1111, 4'b0001, 0, 4);
        vec("allOffOn40", 1, 0, 1, 40, nv(30, 74, 55, 71),  4'b0000, 4'b0000, 0, 0);
        vec("on40",       1, 0, 0, 40, nv(40, 74, 55, 71),  4'b0001, 4'b0001, 0, 1);
        vec("on41",       1, 0, 0, 41, nv(40, 41, 55, 71),  4'b0011, 4'b0010, 0, 2);
        vec("idlePreRst", 0, 0, 0, 0,  nv(40, 41, 55, 71),  4'b0011, 4'b0000, 0, 2);
        drain();

        // Asynchronous reset between clock edges
        #2;
        nrst = 1'b0;
        #1;
        checkNow("asyncReset", nv(0, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, 0);
        #3;
        nrst = 1'b1;

        // After reset: five notes steal voice 0, then release / reuse / retrigger
        vec("b60",        1, 0, 0, 60, nv(60, 0, 0, 0),     4'b0001, 4'b0001, 0, 1);
        vec("b64",        1, 0, 0, 64, nv(60, 64, 0, 0),    4'b0011, 4'b0010, 0, 2);
        vec("b67",        1, 0, 0, 67, nv(60, 64, 67, 0),   4'b0111, 4'b0100, 0, 3);
        vec("b71",        1, 0, 0, 71, nv(60, 64, 67, 71),  4'b1111, 4'b1000, 0, 4);
        vec("b72steal",   1, 0, 0, 72, nv(72, 64, 67, 71),  4'b1111, 4'b0001, 1, 4);
        vec("bOff64",     0, 1, 0, 64, nv(72, 64, 67, 71),  4'b1101, 4'b0000, 0, 3);
        vec("bOn50",      1, 0, 0, 50, nv(72, 50, 67, 71),  4'b1111, 4'b0010, 0, 4);
        vec("bRetrig72",  1, 0, 0, 72, nv(72, 50, 67, 71),  4'b1111, 4'b0001, 0, 4);
        vec("bSteal99",   1, 0, 0, 99, nv(72, 50, 99, 71),  4'b1111, 4'b0100, 1, 4);
        vec("bSteal98",   1, 0, 0, 98, nv(72, 50, 99, 98),  4'b1111, 4'b1000, 1, 4);
        vec("bSteal97",   1, 0, 0, 97, nv(72, 97, 99, 98),  4'b1111, 4'b0010, 1, 4);
        vec("bIdle",      0, 0, 0, 0,  nv(72, 97, 99, 98),  4'b1111, 4'b0000, 0, 4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
`default_nettype wire
